// File: rtl/bounded_counter_pkg.sv
// ----------------------------------------------------------------------------
// bounded_counter_pkg
//
// Shared types and encodings for the bounded counter block.
//   counter_mode_t   : count behaviour selected by the 2-bit mode input
//   one_shot_state_t : run/finished state used by ONE_SHOT mode
//   MODE_*           : raw encodings of the mode input, for drivers that do
//                      not use the enum type directly
// ----------------------------------------------------------------------------
package bounded_counter_pkg;

    typedef enum logic [1:0] {
        WRAP     = 2'd0,
        SATURATE = 2'd1,
        BOUNCE   = 2'd2,
        ONE_SHOT = 2'd3
    } counter_mode_t;

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } one_shot_state_t;

    localparam logic [1:0] MODE_WRAP     = 2'd0;
    localparam logic [1:0] MODE_SATURATE = 2'd1;
    localparam logic [1:0] MODE_BOUNCE   = 2'd2;
    localparam logic [1:0] MODE_ONE_SHOT = 2'd3;

endpackage

// File: rtl/bounded_counter_step.sv
// ----------------------------------------------------------------------------
// bounded_counter_step
//
// Purely combinational next-value calculator for bounded_counter. Given the
// current count, direction and mode it produces the value, direction and
// terminal flag that one count update would produce.
//
// Ports:
//   curVal_i    : current registered count
//   curDirUp_i  : current registered direction (1 = up)
//   upIn_i      : requested direction for non-BOUNCE modes
//   step_i      : magnitude of the update
//   mode_i      : counting mode
//   nextVal_o   : count after the update
//   nextDirUp_o : direction after the update
//   terminal_o  : update reached or crossed a bound (mode-specific rules)
//   atBound_o   : SATURATE/ONE_SHOT result sits on the bound it counts toward
// ----------------------------------------------------------------------------
module bounded_counter_step
    import bounded_counter_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int MIN        = 0,
    parameter int MAX        = 65535,
    parameter int STEP_WIDTH = 4
) (
    input  logic [WIDTH-1:0]      curVal_i,
    input  logic                  curDirUp_i,
    input  logic                  upIn_i,
    input  logic [STEP_WIDTH-1:0] step_i,
    input  counter_mode_t         mode_i,
    output logic [WIDTH-1:0]      nextVal_o,
    output logic                  nextDirUp_o,
    output logic                  terminal_o,
    output logic                  atBound_o
);

    // Two spare bits: one for carry past MAX, one sign bit so that counting
    // below zero is a real negative number rather than a silent wrap.
    localparam int EW = WIDTH + 2;
    localparam logic signed [EW-1:0] MinExt   = EW'(MIN);
    localparam logic signed [EW-1:0] MaxExt   = EW'(MAX);
    localparam logic signed [EW-1:0] RangeExt = EW'(MAX - MIN + 1);

    logic signed [EW-1:0] curExt;
    logic signed [EW-1:0] stepExt;
    logic signed [EW-1:0] sumExt;
    logic signed [EW-1:0] boundExt;
    logic signed [EW-1:0] resExt;
    logic                 dirUp;
    logic                 over;
    logic                 under;
    logic                 hitBound;

    // BOUNCE follows its own direction register; every other mode follows
    // the direction requested on this cycle.
    always_comb begin
        dirUp    = (mode_i == BOUNCE) ? curDirUp_i : upIn_i;
        curExt   = $signed({2'b00, curVal_i});
        stepExt  = $signed({{(EW-STEP_WIDTH){1'b0}}, step_i});
        sumExt   = dirUp ? (curExt + stepExt) : (curExt - stepExt);
        boundExt = dirUp ? MaxExt : MinExt;
        over     = dirUp && (sumExt > MaxExt);
        under    = !dirUp && (sumExt < MinExt);
        hitBound = (sumExt == boundExt);
    end

    // Step never exceeds the range, so a single wrap or a single reflection
    // always lands back inside [MIN,MAX]. A zero step is a no-op in every
    // mode, including keeping the old direction.
    always_comb begin
        resExt      = sumExt;
        nextDirUp_o = upIn_i;
        terminal_o  = 1'b0;
        atBound_o   = 1'b0;
        case (mode_i)
            WRAP: begin
                if (over) begin
                    resExt = sumExt - RangeExt;
                end else if (under) begin
                    resExt = sumExt + RangeExt;
                end
                terminal_o = over || under || hitBound;
            end
            SATURATE, ONE_SHOT: begin
                if (over || under) begin
                    resExt = boundExt;
                end
                atBound_o  = (resExt == boundExt);
                terminal_o = (curExt != boundExt) && (resExt == boundExt);
            end
            BOUNCE: begin
                if (over) begin
                    resExt = MaxExt - (sumExt - MaxExt);
                end else if (under) begin
                    resExt = MinExt + (MinExt - sumExt);
                end
                nextDirUp_o = (over || under || hitBound) ? !curDirUp_i : curDirUp_i;
                terminal_o  = over || under || hitBound;
            end
            default: begin
                resExt = curExt;
            end
        endcase
        if (step_i == '0) begin
            resExt      = curExt;
            nextDirUp_o = curDirUp_i;
            terminal_o  = 1'b0;
            atBound_o   = 1'b0;
        end
    end

    assign nextVal_o = WIDTH'(resExt);

endmodule

// File: rtl/bounded_counter.sv
// ----------------------------------------------------------------------------
// bounded_counter
//
// Registered up/down counter confined to [MIN,MAX] with a programmable step
// and four modes: WRAP, SATURATE, BOUNCE and ONE_SHOT.
//
// Ports:
//   clock      : rising-edge clock
//   reset_     : synchronous reset, active high
//   enable_    : perform one count update this cycle
//   load_      : load load_value (clamped into range) and re-arm
//   load_value : value to load
//   step       : magnitude of each update
//   up_        : direction for WRAP/SATURATE/ONE_SHOT, start direction on load
//   mode       : counter_mode_t encoding
//   out        : registered count
//   direction_ : registered direction (1 = up)
//   terminal_  : one-cycle pulse when an update reached/crossed a bound
//   done_      : ONE_SHOT has finished (level)
//
// Optional build macro BOUNDED_COUNTER_PRESCALER_EN: when defined, only every
// PRESCALE-th enabled cycle performs an update.
// ----------------------------------------------------------------------------
module bounded_counter
    import bounded_counter_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int MIN        = 0,
    parameter int MAX        = 65535,
    parameter int STEP_WIDTH = 4,
    parameter int PRESCALE   = 4
) (
    input  logic                  clock,
    input  logic                  reset_,
    input  logic                  enable_,
    input  logic                  load_,
    input  logic [WIDTH-1:0]      load_value,
    input  logic [STEP_WIDTH-1:0] step,
    input  logic                  up_,
    input  logic [1:0]            mode,
    output logic [WIDTH-1:0]      out,
    output logic                  direction_,
    output logic                  terminal_,
    output logic                  done_
);

    localparam logic [WIDTH-1:0] MinVal = WIDTH'(MIN);
    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX);

    counter_mode_t   modeT;
    one_shot_state_t stateQ, stateD;
    logic [WIDTH-1:0] countQ, countD;
    logic             dirQ, dirD;
    logic             termQ, termD;
    logic [WIDTH-1:0] loadClamped;
    logic             activeEnable;
    logic             update;
    logic [WIDTH-1:0] stepVal;
    logic             stepDir;
    logic             stepTerm;
    logic             stepAtBound;

    assign modeT = counter_mode_t'(mode);

    // A finished one-shot ignores enable_ entirely, prescaler included.
    assign activeEnable = enable_ && !((modeT == ONE_SHOT) && (stateQ == DONE));

`ifdef BOUNDED_COUNTER_PRESCALER_EN
    localparam int PsW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PsW-1:0] PsLast = PsW'(PRESCALE - 1);

    logic [PsW-1:0] prescaleQ, prescaleD;

    assign update = activeEnable && (prescaleQ == PsLast);
`else
    assign update = activeEnable;
`endif

    always_comb begin
        if (load_value < MinVal) begin
            loadClamped = MinVal;
        end else if (load_value > MaxVal) begin
            loadClamped = MaxVal;
        end else begin
            loadClamped = load_value;
        end
    end

    bounded_counter_step #(
        .WIDTH      (WIDTH),
        .MIN        (MIN),
        .MAX        (MAX),
        .STEP_WIDTH (STEP_WIDTH)
    ) u_step (
        .curVal_i    (countQ),
        .curDirUp_i  (dirQ),
        .upIn_i      (up_),
        .step_i      (step),
        .mode_i      (modeT),
        .nextVal_o   (stepVal),
        .nextDirUp_o (stepDir),
        .terminal_o  (stepTerm),
        .atBound_o   (stepAtBound)
    );

    // State register: all flops of the block. Reset beats everything else.
    always_ff @(posedge clock) begin
        if (reset_) begin
            countQ <= MinVal;
            dirQ   <= 1'b1;
            termQ  <= 1'b0;
            stateQ <= RUN;
`ifdef BOUNDED_COUNTER_PRESCALER_EN
            prescaleQ <= '0;
`endif
        end else begin
            countQ <= countD;
            dirQ   <= dirD;
            termQ  <= termD;
            stateQ <= stateD;
`ifdef BOUNDED_COUNTER_PRESCALER_EN
            prescaleQ <= prescaleD;
`endif
        end
    end

    // Next-state logic: load wins over enable. Switching away from ONE_SHOT
    // drops back to RUN so done_ clears, independent of enable_.
    always_comb begin
        countD = countQ;
        dirD   = dirQ;
        termD  = 1'b0;
        stateD = stateQ;
`ifdef BOUNDED_COUNTER_PRESCALER_EN
        prescaleD = prescaleQ;
`endif
        if (load_) begin
            countD = loadClamped;
            dirD   = up_;
            stateD = RUN;
`ifdef BOUNDED_COUNTER_PRESCALER_EN
            prescaleD = '0;
`endif
        end else begin
            if (update) begin
                countD = stepVal;
                dirD   = stepDir;
                termD  = stepTerm;
                if ((modeT == ONE_SHOT) && stepAtBound) begin
                    stateD = DONE;
                end
            end
            if (modeT != ONE_SHOT) begin
                stateD = RUN;
            end
`ifdef BOUNDED_COUNTER_PRESCALER_EN
            if (update) begin
                prescaleD = '0;
            end else if (activeEnable) begin
                prescaleD = prescaleQ + 1'b1;
            end
`endif
        end
    end

    // Output logic: straight decode of the registers.
    always_comb begin
        out        = countQ;
        direction_ = dirQ;
        terminal_  = termQ;
        done_      = (stateQ == DONE);
    end

endmodule

// File: tb/tb_bounded_counter.sv
// ----------------------------------------------------------------------------
// tb_bounded_counter
//
// Drives bounded_counter (WIDTH=8, MIN=10, MAX=20, STEP_WIDTH=3) with directed
// sequences followed by random traffic. Each driven cycle pushes the outputs
// expected after that clock edge; a separate monitor pops and compares them.
// ----------------------------------------------------------------------------
module tb_bounded_counter;
    import bounded_counter_pkg::*;

    localparam int W   = 8;
    localparam int LO  = 10;
    localparam int HI  = 20;
    localparam int SW  = 3;
    localparam int PS  = 3;
    localparam int RNG = HI - LO + 1;

    logic          clock = 1'b0;
    logic          reset_ = 1'b0;
    logic          enable_ = 1'b0;
    logic          load_ = 1'b0;
    logic [W-1:0]  load_value = '0;
    logic [SW-1:0] step = '0;
    logic          up_ = 1'b1;
    logic [1:0]    mode = MODE_WRAP;
    logic [W-1:0]  out;
    logic          direction_;
    logic          terminal_;
    logic          done_;

    typedef struct {
        int    out;
        bit    dir;
        bit    term;
        bit    done;
        string name;
    } exp_t;

    exp_t expQ[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Behavioural model state
    int mCount = LO;
    bit mDir = 1'b1;
    bit mDone = 1'b0;
    int mPs = 0;

    bounded_counter #(
        .WIDTH      (W),
        .MIN        (LO),
        .MAX        (HI),
        .STEP_WIDTH (SW),
        .PRESCALE   (PS)
    ) dut (
        .clock      (clock),
        .reset_     (reset_),
        .enable_    (enable_),
        .load_      (load_),
        .load_value (load_value),
        .step       (step),
        .up_        (up_),
        .mode       (mode),
        .out        (out),
        .direction_ (direction_),
        .terminal_  (terminal_),
        .done_      (done_)
    );

    always #5 clock = ~clock;

    function automatic int clampInt(int v);
        if (v < LO) return LO;
        if (v > HI) return HI;
        return v;
    endfunction

    // One clock of stimulus: drive inputs on the falling edge, advance the
    // reference model and queue the outputs expected after the next rise.
    task automatic applyStimulus(input bit rst, input bit ld, input int ldv,
                                 input bit en, input int stp, input bit up,
                                 input int md, input string name);
        exp_t e;
        bit   term;
        bit   doUpd;
        int   s;
        int   target;
        bit   d;
        @(negedge clock);
        reset_     = rst;
        load_      = ld;
        load_value = W'(ldv);
        enable_    = en;
        step       = SW'(stp);
        up_        = up;
        mode       = 2'(md);

        term = 1'b0;
        if (rst) begin
            mCount = LO; mDir = 1'b1; mDone = 1'b0; mPs = 0;
        end else if (ld) begin
            mCount = clampInt(ldv); mDir = up; mDone = 1'b0; mPs = 0;
        end else begin
            doUpd = en && !(md == 3 && mDone);
            if (md != 3) mDone = 1'b0;
`ifdef BOUNDED_COUNTER_PRESCALER_EN
            if (doUpd) begin
                mPs++;
                if (mPs == PS) mPs = 0;
                else doUpd = 1'b0;
            end
`endif
            if (doUpd && stp != 0) begin
                d = (md == 2) ? mDir : up;
                s = d ? mCount + stp : mCount - stp;
                target = d ? HI : LO;
                case (md)
                    0: begin
                        if (s > HI) begin mCount = s - RNG; term = 1'b1; end
                        else if (s < LO) begin mCount = s + RNG; term = 1'b1; end
                        else begin mCount = s; term = (s == target); end
                        mDir = up;
                    end
                    2: begin
                        if (s > HI) begin mCount = HI - (s - HI); mDir = !mDir; term = 1'b1; end
                        else if (s < LO) begin mCount = LO + (LO - s); mDir = !mDir; term = 1'b1; end
                        else if (s == target) begin mCount = s; mDir = !mDir; term = 1'b1; end
                        else mCount = s;
                    end
                    default: begin
                        term = (mCount != target) && (clampInt(s) == target);
                        mCount = clampInt(s);
                        mDir = up;
                        if (md == 3 && mCount == target) mDone = 1'b1;
                    end
                endcase
            end
        end
        e.out = mCount; e.dir = mDir; e.term = term; e.done = mDone; e.name = name;
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        vectors++;
        if (out !== W'(e.out) || direction_ !== e.dir || terminal_ !== e.term || done_ !== e.done) begin
            miscompares++;
            $display("[TB] FAIL %s: got out=%0d dir=%0b term=%0b done=%0b, want out=%0d dir=%0b term=%0b done=%0b",
                     e.name, out, direction_, terminal_, done_, e.out, e.dir, e.term, e.done);
        end
    endtask

    // Monitor: the counter presents a result every cycle, so one expectation
    // is consumed shortly after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        int md;
        int waitCycles;
        $display("[TB] start");
        applyStimulus(1, 0, 0, 0, 0, 1, 0, "reset");
        applyStimulus(0, 0, 0, 0, 0, 1, 0, "idle_after_reset");

        // WRAP across the top
        applyStimulus(0, 1, 18, 0, 3, 1, 0, "wrap_load");
        applyStimulus(0, 0, 0, 1, 3, 1, 0, "wrap_cross");
        applyStimulus(0, 0, 0, 0, 3, 1, 0, "wrap_term_clear");
        applyStimulus(0, 1, 12, 0, 2, 0, 0, "wrap_load_dn");
        applyStimulus(0, 0, 0, 1, 2, 0, 0, "wrap_hit_min");
        applyStimulus(0, 0, 0, 1, 2, 0, 0, "wrap_under");

        // SATURATE down
        applyStimulus(0, 1, 12, 0, 5, 0, 1, "sat_load");
        applyStimulus(0, 0, 0, 1, 5, 0, 1, "sat_hit");
        applyStimulus(0, 0, 0, 1, 5, 0, 1, "sat_hold");

        // BOUNCE reflecting off MAX
        applyStimulus(0, 1, 19, 0, 3, 1, 2, "bounce_load");
        applyStimulus(0, 0, 0, 1, 3, 1, 2, "bounce_reflect");
        applyStimulus(0, 0, 0, 1, 3, 1, 2, "bounce_down");

        // ONE_SHOT up to MAX, then held, then re-armed by load
        applyStimulus(0, 1, 17, 0, 2, 1, 3, "oneshot_load");
        applyStimulus(0, 0, 0, 1, 2, 1, 3, "oneshot_1");
        applyStimulus(0, 0, 0, 1, 2, 1, 3, "oneshot_2");
        applyStimulus(0, 0, 0, 1, 2, 1, 3, "oneshot_3");
        applyStimulus(0, 0, 0, 1, 2, 1, 3, "oneshot_4");
        applyStimulus(0, 1, 15, 0, 2, 1, 3, "oneshot_rearm");

        // Priority, load clamping and zero step
        applyStimulus(0, 1, 15, 0, 0, 0, 0, "pre_prio_load");
        applyStimulus(1, 1, 15, 1, 3, 0, 0, "reset_over_load");
        applyStimulus(0, 1, 5, 1, 3, 1, 0, "clamp_low");
        applyStimulus(0, 1, 200, 1, 3, 1, 0, "clamp_high");
        applyStimulus(0, 0, 0, 1, 0, 0, 0, "step_zero");
        applyStimulus(0, 0, 0, 1, 0, 1, 1, "step_zero_sat");

`ifdef BOUNDED_COUNTER_PRESCALER_EN
        applyStimulus(0, 1, 10, 0, 1, 1, 0, "ps_load");
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 1, 1, 1, 0, "ps_enable");
        applyStimulus(0, 1, 10, 0, 1, 1, 0, "ps_reload");
        applyStimulus(0, 0, 0, 1, 1, 1, 0, "ps_mid_a");
        applyStimulus(0, 0, 0, 1, 1, 1, 0, "ps_mid_b");
        applyStimulus(0, 1, 10, 0, 1, 1, 0, "ps_restart");
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 1, 1, 0, "ps_after_restart");
`endif

        // Random traffic
        md = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) md = $urandom_range(0, 3);
            applyStimulus($urandom_range(0, 99) == 0,
                          $urandom_range(0, 11) == 0,
                          $urandom_range(0, 255),
                          $urandom_range(0, 3) != 0,
                          $urandom_range(0, 7),
                          $urandom_range(0, 1) == 1,
                          md, "random");
        end

        waitCycles = 0;
        while (expQ.size() > 0 && waitCycles < 10) begin
            @(negedge clock);
            waitCycles++;
        end
        if (expQ.size() > 0) begin
            miscompares++;
            $display("[TB] FAIL drain: %0d expectations left, want 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
